rr_encoder_reg: RTL and testbench
=================================

Name: rr_encoder_reg

Overview:
- Parametrised, registered successor to the 4-to-2 one-hot encoder.
- Accepts N request lines, holds them in a sticky pending register, and serialises them into binary index codes on a valid/ready output.
- Supports fixed-priority or round-robin selection, and reports overflow and multi-hot occupancy.
- Sits between raw event/digit-select sources and downstream converters (e.g. the binary-to-BCD path) that consume one index per transfer.

Parameters:
- N, 8, number of request lines (2..64).
- W, $clog2(N), width of the output code.
- MODE, 0, selection policy: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  qualifies req_in this cycle.
- req_in  input  N  request vector; any number of bits may be set.
- out_ready  input  1  downstream accepts out_code this cycle.
- out_valid  output  1  out_code holds a valid index.
- out_code  output  W  binary index of the granted request.
- pending  output  N  current sticky request register.
- busy  output  1  high when pending != 0 or out_valid = 1.
- multi  output  1  registered; set on a load when more than one pending bit existed at selection time.
- overflow  output  1  one-cycle pulse: a requested bit was already pending and is not being cleared this cycle.

Behaviour:
- Reset (async, on assertion): pending = 0, out_valid = 0, out_code = 0, multi = 0, overflow = 0, rr pointer = N-1 (so the first round-robin search starts at index 0).
- Reset deasserted mid-operation: all captured requests and any in-flight output are discarded.
- Request capture at each edge:
  - req_eff = req_valid ? req_in : 0
  - pending_next = (pending & ~clr) | req_eff
  - clr is the one-hot of the index loaded this cycle, or 0 if nothing is loaded.
- Simultaneous clear and re-request of the same bit: the request wins, the bit stays set, and no overflow is raised.
- Overflow: overflow_next = |(req_eff & pending & ~clr).
- Selection uses registered pending only; req_in never reaches the output combinationally. Minimum latency is 2 edges: capture at edge t, out_valid at edge t+1.
- Load condition: load = (!out_valid || out_ready) && (pending != 0).
  - On load: out_code = selected index, out_valid = 1, multi = (popcount(pending) > 1), clr = onehot(selected).
- Consume without refill: if out_valid && out_ready && pending == 0, then out_valid = 0. out_code and multi hold their last values.
- Stall: if out_valid && !out_ready, out_code, out_valid and multi hold, and pending keeps accumulating.
- Throughput: one code per cycle when out_ready is held high.
- MODE 0: the lowest set index of pending is selected.
- MODE 1:
  - The search starts at (ptr+1) mod N, wraps past N-1 to 0, and the first set bit is selected.
  - ptr updates to the selected index on load only.
  - Wrap rule: with ptr = N-1, the search starts at index 0.
- pending == 0 with no load: no state change, except out_valid clearing on consume as above.
- Out-of-range codes are never produced; out_code is always < N.

Test Plan:
- N=8, MODE=0, out_ready=1, single req_in=8'b0000_0100 pulse at edge t -> pending=8'h04 after t; out_valid=1, out_code=2, multi=0 after t+1; pending=0 and busy=0 after t+2.
- MODE=0, req_in=8'b1001_0010 one cycle, out_ready=1 -> codes 1, 4, 7 on consecutive cycles; multi=1, 1, 0; out_valid drops on the following cycle.
- MODE=1, pending held at 8'b1000_0001 by re-requesting both bits every cycle, out_ready=1 -> codes alternate 0, 7, 0, 7 with ptr wrapping; no overflow on a bit's clear cycle, and overflow=1 on cycles where the other pending bit is re-requested.
- Backpressure: out_code=3 valid with out_ready=0 for 4 cycles while req_in=8'h20 arrives -> out_code stays 3; pending=8'h20; a second 8'h20 request pulses overflow=1 once; after out_ready=1 the next code is 5.
- Reset mid-stream: pending=8'hFF, out_valid=1, assert reset asynchronously between edges -> all outputs 0 immediately; after release, the first MODE=1 grant of req 8'h81 is code 0.
- Idle: req_valid=0 with req_in=8'hFF for 10 cycles -> pending=0, out_valid=0, busy=0, overflow=0 throughout.

Source files
------------

// File: rtl/rr_encoder_reg.sv
// Registered N-way request encoder: sticky pending register drained one binary
// index per transfer on a valid/ready output, fixed-priority or round-robin.
module rr_encoder_reg #(
    parameter int N    = 8,
    parameter int W    = $clog2(N),
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    input  logic [N-1:0] req_in,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_code,
    output logic [N-1:0] pending,
    output logic         busy,
    output logic         multi,
    output logic         overflow
);

    logic [N-1:0] r_pending;
    logic         r_out_valid;
    logic [W-1:0] r_out_code;
    logic         r_multi;
    logic         r_overflow;
    logic [W-1:0] r_ptr;

    logic [N-1:0] w_req_eff;
    logic [N-1:0] w_clr;
    logic [W-1:0] w_sel;
    logic         w_found;
    logic         w_load;
    logic         w_many;
    int           w_idx;

    // Search order begins just past the last grant in round-robin mode.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = (MODE == 1) ? ((int'(r_ptr) + 1 + i) % N) : i;
            if (!w_found && r_pending[w_idx]) begin
                w_sel   = W'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    assign w_load    = (!r_out_valid || out_ready) && (r_pending != '0);
    assign w_req_eff = req_valid ? req_in : '0;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_many    = (r_pending & (r_pending - {{(N-1){1'b0}}, 1'b1})) != '0;

    always_comb begin
        w_clr = '0;
        if (w_load) begin
            w_clr[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_multi     <= 1'b0;
            r_overflow  <= 1'b0;
            r_ptr       <= W'(N - 1);
        end else begin
            r_pending  <= (r_pending & ~w_clr) | w_req_eff;
            r_overflow <= |(w_req_eff & r_pending & ~w_clr);
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_code  <= w_sel;
                r_multi     <= w_many;
                r_ptr       <= w_sel;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_code  = r_out_code;
    assign pending   = r_pending;
    assign busy      = (r_pending != '0) || r_out_valid;
    assign multi     = r_multi;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_rr_encoder_reg.sv
// Drives a fixed-priority and a round-robin instance with shared stimulus and
// compares both against a per-transfer reference model.
module tb_rr_encoder_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [7:0] req_in = '0;
    logic       out_ready = 1'b0;

    logic       o0_valid, o1_valid, o0_busy, o1_busy;
    logic       o0_multi, o1_multi, o0_ovf, o1_ovf;
    logic [2:0] o0_code, o1_code;
    logic [7:0] o0_pend, o1_pend;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_pend [2];
    bit         m_vld  [2];
    int         m_code [2];
    bit         m_multi[2];
    bit         m_ovf  [2];
    int         m_ptr  [2];

    rr_encoder_reg #(.N(8), .MODE(0)) dut0 (
        .clk(clk), .reset(rst), .req_valid(req_valid), .req_in(req_in),
        .out_ready(out_ready), .out_valid(o0_valid), .out_code(o0_code),
        .pending(o0_pend), .busy(o0_busy), .multi(o0_multi), .overflow(o0_ovf)
    );

    rr_encoder_reg #(.N(8), .MODE(1)) dut1 (
        .clk(clk), .reset(rst), .req_valid(req_valid), .req_in(req_in),
        .out_ready(out_ready), .out_valid(o1_valid), .out_code(o1_code),
        .pending(o1_pend), .busy(o1_busy), .multi(o1_multi), .overflow(o1_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_sel(input int m);
        if (m == 0) begin
            for (int i = 0; i < 8; i++)
                if (m_pend[m][i]) return i;
        end else begin
            for (int k = 1; k <= 8; k++)
                if (m_pend[m][(m_ptr[m] + k) % 8]) return (m_ptr[m] + k) % 8;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0; m_vld[m] = 0; m_code[m] = 0;
            m_multi[m] = 0; m_ovf[m] = 0; m_ptr[m] = 7;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".m0.valid"}, 64'(o0_valid), 64'(m_vld[0]));
        chk({tag, ".m0.code"},  64'(o0_code),  64'(m_code[0]));
        chk({tag, ".m0.pend"},  64'(o0_pend),  64'(m_pend[0]));
        chk({tag, ".m0.busy"},  64'(o0_busy),  64'((m_pend[0] != 0) || m_vld[0]));
        chk({tag, ".m0.multi"}, 64'(o0_multi), 64'(m_multi[0]));
        chk({tag, ".m0.ovf"},   64'(o0_ovf),   64'(m_ovf[0]));
        chk({tag, ".m1.valid"}, 64'(o1_valid), 64'(m_vld[1]));
        chk({tag, ".m1.code"},  64'(o1_code),  64'(m_code[1]));
        chk({tag, ".m1.pend"},  64'(o1_pend),  64'(m_pend[1]));
        chk({tag, ".m1.busy"},  64'(o1_busy),  64'((m_pend[1] != 0) || m_vld[1]));
        chk({tag, ".m1.multi"}, 64'(o1_multi), 64'(m_multi[1]));
        chk({tag, ".m1.ovf"},   64'(o1_ovf),   64'(m_ovf[1]));
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input bit rv, input logic [7:0] rin, input bit rdy, input string tag);
        logic [7:0] eff, clr;
        bit load;
        int sel;
        req_valid = rv; req_in = rin; out_ready = rdy;
        eff = rv ? rin : 8'h00;
        for (int m = 0; m < 2; m++) begin
            load = (!m_vld[m] || rdy) && (m_pend[m] != 0);
            clr = 8'h00;
            sel = 0;
            if (load) begin
                sel = model_sel(m);
                clr = 8'h01 << sel;
            end
            m_ovf[m] = |(eff & m_pend[m] & ~clr);
            if (load) begin
                m_code[m]  = sel;
                m_multi[m] = $countones(m_pend[m]) > 1;
                m_vld[m]   = 1;
                m_ptr[m]   = sel;
            end else if (m_vld[m] && rdy) begin
                m_vld[m] = 0;
            end
            m_pend[m] = (m_pend[m] & ~clr) | eff;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        chk("reset.ptr_code", 64'(o1_code), 64'd0);
        rst = 1'b0;

        // Single request: capture, then grant, then drain.
        step(1, 8'h04, 1, "single.cap");
        chk("single.pend", 64'(o0_pend), 64'h04);
        step(0, 8'h00, 1, "single.grant");
        chk("single.code", 64'(o0_code), 64'd2);
        chk("single.valid", 64'(o0_valid), 64'd1);
        step(0, 8'h00, 1, "single.drain");
        chk("single.busy", 64'(o0_busy), 64'd0);

        // Multi-hot burst drains lowest-first in fixed priority.
        step(1, 8'h92, 1, "burst.cap");
        step(0, 8'h00, 1, "burst.g1");
        chk("burst.code1", 64'(o0_code), 64'd1);
        chk("burst.multi1", 64'(o0_multi), 64'd1);
        step(0, 8'h00, 1, "burst.g2");
        chk("burst.code2", 64'(o0_code), 64'd4);
        step(0, 8'h00, 1, "burst.g3");
        chk("burst.code3", 64'(o0_code), 64'd7);
        chk("burst.multi3", 64'(o0_multi), 64'd0);
        step(0, 8'h00, 1, "burst.end");
        chk("burst.valid_drop", 64'(o0_valid), 64'd0);

        // Round-robin alternation between bits 0 and 7 with continual re-requests.
        for (int i = 0; i < 8; i++) step(1, 8'h81, 1, "rr_alt");
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, "rr_flush");

        // Backpressure: code 3 held while bit 5 accumulates, then released.
        step(1, 8'h08, 0, "bp.cap");
        step(0, 8'h00, 0, "bp.load");
        chk("bp.code3", 64'(o0_code), 64'd3);
        step(1, 8'h20, 0, "bp.req1");
        step(0, 8'h00, 0, "bp.hold");
        step(1, 8'h20, 0, "bp.req2");
        chk("bp.ovf_pulse", 64'(o0_ovf), 64'd1);
        step(0, 8'h00, 0, "bp.hold2");
        chk("bp.code_held", 64'(o0_code), 64'd3);
        step(0, 8'h00, 1, "bp.release");
        chk("bp.code5", 64'(o0_code), 64'd5);
        step(0, 8'h00, 1, "bp.drain");

        // Asynchronous reset with a full pending register and a live output.
        step(1, 8'hFF, 0, "rst.fill");
        step(1, 8'hFF, 0, "rst.load");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("rst.async");
        #2 rst = 1'b0;
        step(1, 8'h81, 1, "rst.rr_cap");
        step(0, 8'h00, 1, "rst.rr_grant");
        chk("rst.rr_code0", 64'(o1_code), 64'd0);
        step(0, 8'h00, 1, "rst.rr_grant2");
        step(0, 8'h00, 1, "rst.rr_drain");

        // Idle with req_valid low must ignore req_in.
        for (int i = 0; i < 10; i++) step(0, 8'hFF, 1, "idle");

        // Randomised traffic with sparse requests and variable backpressure.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            r = 8'($urandom) & 8'($urandom);
            step(($urandom_range(0, 2) != 0), r, ($urandom_range(0, 3) != 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
